mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the pipelined RISC-V core. Consumes the EX/M pipeline register outputs, performs loads and stores on the data-memory bus with a request/grant/response handshake, formats load data, and registers the writeback bundle for the M/WB boundary. Asserts a stall back to the pipeline while a memory transaction is outstanding.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-low.
- `valid_in` in 1: EX/M slot holds a live instruction.
- `rd_addr_in` in 5: destination register.
- `alu_result_in` in 32: ALU result; the effective address for memory ops.
- `store_data_in` in 32: rs2 value for stores.
- `mem_read_in` / `mem_write_in` in 1: load / store (never both).
- `mem_size_in` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `mem_unsigned_in` in 1: zero-extend load (LBU/LHU).
- `writeback_en_in` in 1: instruction writes rd.
- `dmem_req` out 1: bus request.
- `dmem_we` out 1: write request.
- `dmem_addr` out 32: word address, bits [1:0] = 0.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_be` out 4: byte enables.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: read data valid.
- `dmem_rdata` in 32: read data.
- `stall_out` out 1: hold the EX/M register and all upstream stages.
- `valid_out`, `rd_addr_out[4:0]`, `wb_data_out[31:0]`, `writeback_en_out`: registered M/WB bundle.
- `misalign_out` out 1: registered misaligned-access flag (only with `MEM_MISALIGN_TRAP_EN`).

## Operation
- FSM states:
  - IDLE
  - REQ: request issued, waiting for `dmem_gnt`.
  - WAIT: load granted, waiting for `dmem_rvalid`.
- A memory op is `valid_in & (mem_read_in | mem_write_in)`.
- `dmem_req` is combinational: high in IDLE when a memory op is present, and high throughout REQ.
- `dmem_addr`, `dmem_we`, `dmem_be` and `dmem_wdata` are stable while `dmem_req` is high.
- IDLE, memory op present:
  - `gnt` = 1, store: the op completes this cycle.
  - `gnt` = 1, load: go to WAIT.
  - `gnt` = 0: go to REQ.
- REQ: on `gnt`, a store completes; a load goes to WAIT.
- WAIT: on `rvalid`, the load completes and the FSM returns to IDLE. `rvalid` is never presented in the same cycle as `gnt`.
- `stall_out` = memory op present and not completing this cycle. It is combinational and covers IDLE, REQ and WAIT.
- Non-memory op or bubble: the bundle passes through in 1 cycle with `wb_data_out` = `alu_result_in`, and `stall_out` = 0.
- While `stall_out` = 1, the output register loads a bubble (`valid_out` = 0, `writeback_en_out` = 0). On completion it loads the real result.
- Byte enables:
  - byte: `4'b0001 << a[1:0]`
  - half: `4'b0011 << {a[1],1'b0}`
  - word: `4'hF`
- Store write data:
  - byte: `{4{sd[7:0]}}`
  - half: `{2{sd[15:0]}}`
  - word: `sd`
- Load formatting: select the lane by `a[1:0]` (byte) or `a[1]` (half), then sign- or zero-extend to 32 bits per `mem_unsigned_in`.
- `writeback_en_out` is forced to 0 when `rd_addr_in` = 0.
- `dmem_rvalid` arriving in IDLE or REQ is ignored.

## Timing
- Reset values: state IDLE; `valid_out`, `writeback_en_out`, `misalign_out` = 0; `rd_addr_out` = 0; `wb_data_out` = 0.
- While `rst` = 0, `dmem_req` = 0 and `stall_out` = 0.
- Reset mid-transaction: the FSM returns to IDLE and the transaction is abandoned. A late `rvalid` is ignored.
- Latency, first edge counted after the op enters EX/M:
  - ALU op: 1 cycle.
  - Store with immediate grant: 1 cycle.
  - Load with immediate grant and next-cycle `rvalid`: 2 cycles.
  - Each `gnt` or `rvalid` wait cycle adds 1.
- Back-to-back memory ops: the FSM may leave IDLE again on the cycle immediately after returning to IDLE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A half access with `a[0]` = 1, or a word access with `a[1:0]` ≠ 0, issues no bus request.
  - It completes in 1 cycle with `misalign_out` = 1, `writeback_en_out` = 0, `valid_out` = 1.
- Undefined:
  - `misalign_out` is absent.
  - Address low bits are forced to natural alignment: half uses `a[1]` only; word ignores `a[1:0]`.

## Structure
- `riscv_pkg`:
  - `mem_size_t` enum: `MEM_B`, `MEM_H`, `MEM_W`.
  - `mem_state_t` enum: IDLE, REQ, WAIT.
- Sub-module `mem_lane_fmt`: combinational byte-enable / store-replication / load-extraction logic, reused by both lane paths.

## Test plan
- ALU op, `rd`=5, `alu_result`=`32'h1234`, `writeback_en`=1 -> next cycle `valid_out`=1, `rd_addr_out`=5, `wb_data_out`=`32'h1234`, no `dmem_req`.
- SB, addr=`32'h103`, data=`32'hAB`, `gnt` same cycle -> `dmem_addr`=`32'h100`, `be`=`4'b1000`, `wdata`=`32'hABABABAB`, `stall_out`=0.
- LH signed, addr=`32'h202`, `gnt` delayed 2 cycles, `rdata`=`32'h8001_xxxx` -> `stall_out` held 3 cycles, then `wb_data_out`=`32'hFFFF8001`.
- LBU, addr=`32'h301`, `rdata`=`32'h0000F000` -> `wb_data_out`=`32'h000000F0`.
- Reset asserted in WAIT, then `rvalid`=1 -> outputs at reset values, `valid_out` stays 0.
- LW, addr=`32'h402`: with the macro -> `misalign_out`=1, no request. Without the macro -> `dmem_addr`=`32'h400`, `be`=`4'hF`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory-access stage: access sizes, FSM states, M/WB bundle.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = XLEN / 8;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   wb_data;
        logic              wb_en;
    } wb_bundle_t;

    // Encoding 3 is treated as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        case (raw)
            2'd0:    return MEM_B;
            2'd1:    return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] a);
        case (size)
            MEM_H:   return a[0];
            MEM_W:   return (a != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: byte enables and store replication toward the bus,
// lane extraction and sign/zero extension of load data coming back.
module mem_lane_fmt
    import riscv_pkg::*;
(
    input  mem_size_t         size,
    input  logic [1:0]        addr_lo,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [BE_W-1:0]   be_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   load_data_c
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane pick; half accesses only look at addr_lo[1], forcing natural alignment.
    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be_c        = 4'hF;
        wdata_c     = store_data;
        load_data_c = rdata;
        case (size)
            MEM_B: begin
                be_c        = BE_W'(4'b0001 << addr_lo);
                wdata_c     = {4{store_data[7:0]}};
                load_data_c = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            MEM_H: begin
                be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c     = {2{store_data[15:0]}};
                load_data_c = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            default: begin
                be_c        = 4'hF;
                wdata_c     = store_data;
                load_data_c = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-bus handshake FSM, load formatting, M/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into flagged no-ops.
module mem_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [4:0]        rd_addr_in,
    input  logic [31:0]       alu_result_in,
    input  logic [31:0]       store_data_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [1:0]        mem_size_in,
    input  logic              mem_unsigned_in,
    input  logic              writeback_en_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [31:0]       dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              stall_out,
    output logic              valid_out,
    output logic [4:0]        rd_addr_out,
    output logic [31:0]       wb_data_out,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              misalign_out,
`endif
    output logic              writeback_en_out
);

    mem_state_t        state_q, state_d;
    wb_bundle_t        wb_q, wb_d;
    mem_size_t         size_c;
    logic              misalign_c;
    logic              mem_op_c;
    logic              req_c;
    logic              complete_c;
    logic [BE_W-1:0]   be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   load_data_c;

    assign size_c = decode_size(mem_size_in);

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign misalign_c = valid_in & (mem_read_in | mem_write_in)
                      & is_misaligned(size_c, alu_result_in[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Misaligned accesses (trap build only) never reach the bus.
    assign mem_op_c = rst & valid_in & (mem_read_in | mem_write_in) & ~misalign_c;

    mem_lane_fmt u_lane_fmt (
        .size        (size_c),
        .addr_lo     (alu_result_in[1:0]),
        .is_unsigned (mem_unsigned_in),
        .store_data  (store_data_in),
        .rdata       (dmem_rdata),
        .be_c        (be_c),
        .wdata_c     (wdata_c),
        .load_data_c (load_data_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Handshake: IDLE issues, REQ waits for grant, WAIT waits for read data.
    always_comb begin
        state_d    = state_q;
        req_c      = 1'b0;
        complete_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    req_c = 1'b1;
                    if (dmem_gnt) begin
                        if (mem_write_in) complete_c = 1'b1;
                        else              state_d    = WAIT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                req_c = 1'b1;
                if (dmem_gnt) begin
                    if (mem_write_in) begin
                        complete_c = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    complete_c = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            req_c      = 1'b0;
            complete_c = 1'b0;
        end
    end

    assign dmem_req   = req_c;
    assign dmem_we    = req_c & mem_write_in;
    assign dmem_addr  = {alu_result_in[31:2], 2'b00};
    assign dmem_wdata = wdata_c;
    assign dmem_be    = req_c ? be_c : 4'h0;
    assign stall_out  = mem_op_c & ~complete_c;

    // A stalled slot becomes a bubble; completed or non-memory slots carry their result.
    always_comb begin
        wb_d = '0;
        if (valid_in && !stall_out) begin
            wb_d.valid   = 1'b1;
            wb_d.rd_addr = rd_addr_in;
            wb_d.wb_en   = writeback_en_in & (rd_addr_in != 5'd0) & ~misalign_c;
            wb_d.wb_data = (mem_op_c & mem_read_in) ? load_data_c : alu_result_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) wb_q <= '0;
        else      wb_q <= wb_d;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_d = valid_in & ~stall_out & misalign_c;

    always_ff @(posedge clk) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end

    assign misalign_out = misalign_q;
`endif

    assign valid_out        = wb_q.valid;
    assign rd_addr_out      = wb_q.rd_addr;
    assign wb_data_out      = wb_q.wb_data;
    assign writeback_en_out = wb_q.wb_en;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ops push expected M/WB bundles, a monitor pops on valid_out.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic        writeback_en_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        stall_out;
    logic        valid_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] wb_data_out;
    logic        writeback_en_out;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_out;
`endif

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (valid_in),
        .rd_addr_in       (rd_addr_in),
        .alu_result_in    (alu_result_in),
        .store_data_in    (store_data_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .mem_size_in      (mem_size_in),
        .mem_unsigned_in  (mem_unsigned_in),
        .writeback_en_in  (writeback_en_in),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_be          (dmem_be),
        .dmem_gnt         (dmem_gnt),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .stall_out        (stall_out),
        .valid_out        (valid_out),
        .rd_addr_out      (rd_addr_out),
        .wb_data_out      (wb_data_out),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_out     (misalign_out),
`endif
        .writeback_en_out (writeback_en_out)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wb_en;
        logic        chk_data;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] rd, input logic [31:0] data,
                                input logic wb_en, input logic chk_data, input logic mis);
        exp_t e;
        e.rd = rd; e.data = data; e.wb_en = wb_en; e.chk_data = chk_data; e.mis = mis;
        return e;
    endfunction

    // Monitor: every valid M/WB bundle must match the oldest expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_out=1 expected no pending result (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                check("rd_addr_out", 32'(rd_addr_out), 32'(e.rd));
                check("writeback_en_out", 32'(writeback_en_out), 32'(e.wb_en));
                if (e.chk_data) check("wb_data_out", wb_data_out, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
                check("misalign_out", 32'(misalign_out), 32'(e.mis));
`endif
            end
        end
    end

    // Issue one op at posedge+1 and act as the memory until it completes; ends at posedge+1.
    task automatic run_op(input logic rd_i, input logic wr_i, input logic [1:0] size,
                          input logic uns, input logic [4:0] rd, input logic wbe,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int gnt_dly, input int rv_dly, input logic stray,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input int exp_stalls,
                          input logic no_req, input exp_t e);
        logic is_mem;
        logic granted;
        logic done;
        int   gw, rw, stalls, cyc;
        valid_in        = 1'b1;
        mem_read_in     = rd_i;
        mem_write_in    = wr_i;
        mem_size_in     = size;
        mem_unsigned_in = uns;
        rd_addr_in      = rd;
        writeback_en_in = wbe;
        alu_result_in   = addr;
        store_data_in   = sd;
        sb.push_back(e);
        is_mem = rd_i | wr_i;
        granted = 1'b0; done = 1'b0;
        gw = 0; rw = 0; stalls = 0; cyc = 0;
        while (!done && cyc < 40) begin
            if (!is_mem || no_req) begin
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            end else if (!granted) begin
                dmem_gnt    = (gw == gnt_dly);
                dmem_rvalid = stray && !dmem_gnt;
                dmem_rdata  = 32'h5555AAAA;
            end else begin
                dmem_gnt    = 1'b0;
                dmem_rvalid = (rw == rv_dly);
                dmem_rdata  = rdata;
            end
            @(negedge clk);
            if (stall_out) stalls++;
            if (!is_mem || no_req) begin
                check("dmem_req_low", 32'(dmem_req), 32'd0);
            end else if (!granted) begin
                check("dmem_req", 32'(dmem_req), 32'd1);
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_be", 32'(dmem_be), 32'(exp_be));
                check("dmem_we", 32'(dmem_we), 32'(wr_i));
                if (wr_i) check("dmem_wdata", dmem_wdata, exp_wdata);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!is_mem || no_req) begin
                done = 1'b1;
            end else if (!granted) begin
                if (dmem_gnt) begin
                    granted = 1'b1;
                    if (wr_i) done = 1'b1;
                end else begin
                    gw++;
                end
            end else if (dmem_rvalid) begin
                done = 1'b1;
            end else begin
                rw++;
            end
        end
        if (!done) check("op_timeout", 32'd0, 32'd1);
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        rst = 1'b0;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
        mem_size_in = 2'd2; mem_unsigned_in = 1'b0; rd_addr_in = 5'd3;
        writeback_en_in = 1'b1; alu_result_in = 32'h40; store_data_in = 32'h0;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;

        // Reset holds the bus quiet even with a load presented.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dmem_req", 32'(dmem_req), 32'd0);
        check("reset_stall", 32'(stall_out), 32'd0);
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_wb_data", wb_data_out, 32'd0);
        check("reset_rd_addr", 32'(rd_addr_out), 32'd0);
        check("reset_wb_en", 32'(writeback_en_out), 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0; mem_read_in = 1'b0; dmem_gnt = 1'b0; rst = 1'b1;

        // ALU op passes through
        run_op(0, 0, 2'd2, 0, 5'd5, 1, 32'h1234, 32'h0, 32'h0, 0, 0, 0,
               32'h0, 4'h0, 32'h0, 0, 0, mk(5'd5, 32'h1234, 1, 1, 0));
        // SB to lane 3, immediate grant
        run_op(0, 1, 2'd0, 0, 5'd0, 0, 32'h103, 32'hAB, 32'h0, 0, 0, 0,
               32'h100, 4'b1000, 32'hABABABAB, 0, 0, mk(5'd0, 32'h0, 0, 0, 0));
        // LH signed, grant delayed 2 with stray rvalid while waiting
        run_op(1, 0, 2'd1, 0, 5'd7, 1, 32'h202, 32'h0, 32'h80011234, 2, 0, 1,
               32'h200, 4'b1100, 32'h0, 3, 0, mk(5'd7, 32'hFFFF8001, 1, 1, 0));
        // LBU lane 1
        run_op(1, 0, 2'd0, 1, 5'd8, 1, 32'h301, 32'h0, 32'h0000F000, 0, 0, 0,
               32'h300, 4'b0010, 32'h0, 1, 0, mk(5'd8, 32'h000000F0, 1, 1, 0));
        // SH upper half, grant delayed 1
        run_op(0, 1, 2'd1, 0, 5'd0, 0, 32'h502, 32'h1234ABCD, 32'h0, 1, 0, 0,
               32'h500, 4'b1100, 32'hABCDABCD, 1, 0, mk(5'd0, 32'h0, 0, 0, 0));
        // LB signed, rvalid delayed 2
        run_op(1, 0, 2'd0, 0, 5'd11, 1, 32'h600, 32'h0, 32'h00000080, 0, 2, 0,
               32'h600, 4'b0001, 32'h0, 3, 0, mk(5'd11, 32'hFFFFFF80, 1, 1, 0));
        // ALU op to x0 never writes back
        run_op(0, 0, 2'd2, 0, 5'd0, 1, 32'hDEAD, 32'h0, 32'h0, 0, 0, 0,
               32'h0, 4'h0, 32'h0, 0, 0, mk(5'd0, 32'hDEAD, 0, 1, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned LW traps without a bus request
        run_op(1, 0, 2'd2, 0, 5'd9, 1, 32'h402, 32'h0, 32'h0, 0, 0, 0,
               32'h0, 4'h0, 32'h0, 0, 1, mk(5'd9, 32'h0, 0, 0, 1));
`else
        // Misaligned LW is forced to the aligned word
        run_op(1, 0, 2'd2, 0, 5'd9, 1, 32'h402, 32'h0, 32'hCAFEBABE, 0, 0, 0,
               32'h400, 4'hF, 32'h0, 1, 0, mk(5'd9, 32'hCAFEBABE, 1, 1, 0));
`endif
        // Size encoding 3 behaves as a word
        run_op(1, 0, 2'd3, 0, 5'd12, 1, 32'h700, 32'h0, 32'h11223344, 0, 0, 0,
               32'h700, 4'hF, 32'h0, 1, 0, mk(5'd12, 32'h11223344, 1, 1, 0));
        // LHU lower half
        run_op(1, 0, 2'd1, 1, 5'd13, 1, 32'h800, 32'h0, 32'hAAAA9876, 0, 1, 0,
               32'h800, 4'b0011, 32'h0, 2, 0, mk(5'd13, 32'h00009876, 1, 1, 0));
        // SW full word
        run_op(0, 1, 2'd2, 0, 5'd0, 0, 32'h904, 32'h0BADF00D, 32'h0, 0, 0, 0,
               32'h904, 4'hF, 32'h0BADF00D, 0, 0, mk(5'd0, 32'h0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained_pre_reset", 32'(sb.size()), 32'd0);

        // Reset while a load waits for read data; the late rvalid must be dropped.
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; mem_size_in = 2'd2;
        rd_addr_in = 5'd10; writeback_en_in = 1'b1; alu_result_in = 32'hA00;
        dmem_gnt = 1'b1;
        @(negedge clk);
        check("rst_test_req", 32'(dmem_req), 32'd1);
        @(posedge clk);
        #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("rst_test_wait_stall", 32'(stall_out), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req", 32'(dmem_req), 32'd0);
        check("rst_mid_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0; mem_read_in = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_out", 32'(valid_out), 32'd0);
        check("rst_mid_wb_data", wb_data_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("late_rvalid_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rvalid_valid_out", 32'(valid_out), 32'd0);
        check("late_rvalid_wb_data", wb_data_out, 32'd0);

        // Stage still works after the abandoned transaction.
        @(posedge clk);
        #1;
        run_op(1, 0, 2'd2, 0, 5'd14, 1, 32'hB00, 32'h0, 32'h76543210, 0, 0, 0,
               32'hB00, 4'hF, 32'h0, 1, 0, mk(5'd14, 32'h76543210, 1, 1, 0));
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
